// File: rtl/sysid_probe_ctrl.sv
// Probes an Avalon-MM system ID slave: reads the ID word (address 0), then the
// timestamp word (address 1), and reports whether they match the expected values.
//
// Ports
//   clock, reset      : sole clock; synchronous active-high reset
//   start             : one-cycle probe request (honoured in IDLE, or in DONE once done has dropped)
//   m_address, m_read : registered Avalon-MM read request, held stable while stalled
//   m_waitrequest     : slave stall
//   m_readdata        : read data, captured in the completing cycle
//   id_value/ts_value : last captured ID and timestamp words
//   busy              : probe in progress
//   done              : one-cycle pulse when a probe ends
//   id_ok             : sticky pass result of the last probe
//   timeout           : sticky, last probe aborted on waitrequest timeout
module sysid_probe_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_1337,
  parameter logic [31:0] EXPECTED_TS    = 32'h6796_A245,
  parameter bit          CHECK_TS       = 1'b0,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        timeout
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_ID  = 3'd1,
    S_RD_TS  = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic              auto_armed, auto_armed_d;
  logic              m_read_d, m_address_d, busy_d, done_d, id_ok_d, timeout_d;
  logic [31:0]       id_value_d, ts_value_d;
  logic              launch_c, rd_done_c, rd_abort_c;

  // Read handshake qualifiers; abort fires on the TIMEOUT_CYCLES-th stalled cycle.
  assign rd_done_c  = m_read && !m_waitrequest;
  assign rd_abort_c = m_read && m_waitrequest &&
                      (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  // done is high in the first DONE cycle, so a start coinciding with it is dropped.
  assign launch_c   = (start || auto_armed) &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && !done));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (launch_c) state_d = S_RD_ID;
      S_RD_ID: begin
        if (rd_done_c)       state_d = S_RD_TS;
        else if (rd_abort_c) state_d = S_FINISH;
      end
      S_RD_TS:  if (rd_done_c || rd_abort_c) state_d = S_FINISH;
      S_FINISH: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. Each read state spends its first cycle with
  // m_read low, which provides the gap between the two reads.
  always_comb begin
    m_read_d     = m_read;
    m_address_d  = m_address;
    id_value_d   = id_value;
    ts_value_d   = ts_value;
    id_ok_d      = id_ok;
    timeout_d    = timeout;
    done_d       = 1'b0;
    wait_cnt_d   = wait_cnt;
    auto_armed_d = auto_armed;
    busy_d       = (state_d == S_RD_ID) || (state_d == S_RD_TS) || (state_d == S_FINISH);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch_c) begin
          auto_armed_d = 1'b0;
          id_ok_d      = 1'b0;
          timeout_d    = 1'b0;
          wait_cnt_d   = '0;
          m_read_d     = 1'b0;
          m_address_d  = 1'b0;
        end
      end
      S_RD_ID, S_RD_TS: begin
        if (!m_read) begin
          m_read_d    = 1'b1;
          m_address_d = (state_q == S_RD_TS);
          wait_cnt_d  = '0;
        end else if (!m_waitrequest) begin
          m_read_d   = 1'b0;
          wait_cnt_d = '0;
          if (state_q == S_RD_ID) id_value_d = m_readdata;
          else                    ts_value_d = m_readdata;
        end else if (rd_abort_c) begin
          m_read_d  = 1'b0;
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        id_ok_d = !timeout && (id_value == EXPECTED_ID) &&
                  (!CHECK_TS || (ts_value == EXPECTED_TS));
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      m_read     <= 1'b0;
      m_address  <= 1'b0;
      id_value   <= '0;
      ts_value   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      id_ok      <= 1'b0;
      timeout    <= 1'b0;
      wait_cnt   <= '0;
      auto_armed <= AUTO_START;
    end else begin
      m_read     <= m_read_d;
      m_address  <= m_address_d;
      id_value   <= id_value_d;
      ts_value   <= ts_value_d;
      busy       <= busy_d;
      done       <= done_d;
      id_ok      <= id_ok_d;
      timeout    <= timeout_d;
      wait_cnt   <= wait_cnt_d;
      auto_armed <= auto_armed_d;
    end
  end

endmodule
